regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the single-write MIPS regfile in the core.
- Configurable data width, depth and read-port count.
- Two write ports: W0 for ALU writeback, W1 for load/MEM writeback.
- Per-register scoreboard (busy bits) for hazard detection.
- Sequential clear engine: zeroes the array one entry per cycle after reset, so the array maps to distributed RAM instead of a flop bank with a full reset.

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW entries
NR, 2, number of combinational read ports (1..4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
ready  out  1  high once the clear sweep has finished
ra  in  NR*AW  read addresses; port k uses bits [k*AW +: AW]
rd  out  NR*DW  read data; port k uses bits [k*DW +: DW]
busy_rd  out  NR  scoreboard busy bit for each ra[k]
we0  in  1  write enable, port 0 (ALU)
wa0  in  AW  write address, port 0
wd0  in  DW  write data, port 0
we1  in  1  write enable, port 1 (load)
wa1  in  AW  write address, port 1
wd1  in  DW  write data, port 1
bset  in  1  mark register bwa busy (instruction issued with that destination)
bwa  in  AW  register to mark busy

Behaviour:
Reset and clear FSM, states CLEAR and RUN:
- rst=1 (synchronous, active-high): state<=CLEAR, cnt<=0, all busy bits<=0, ready<=0.
- CLEAR: each cycle rf[cnt]<=0 and cnt<=cnt+1. When cnt==2**AW-1, the last write occurs and state<=RUN.
- ready=1 in the cycle after that final write. Clear takes exactly 2**AW cycles after rst deasserts.
- rst asserted during CLEAR or RUN restarts the sweep at cnt=0; there are no partial-sweep effects.
- In CLEAR: we0, we1 and bset are ignored; rd outputs are 0; busy_rd outputs are 0.

Writes (RUN only, rising edge):
- weX=1 and waX!=0 -> rf[waX]<=wdX.
- Writes to address 0 are discarded.
- we0 and we1 to the same address in the same cycle: W1 wins and the W0 data is lost.

Reads:
- Combinational. rd[k] = 0 if ra[k]==0, otherwise rf[ra[k]].
- Without bypass, a value written in cycle n is visible on rd in cycle n+1.

Scoreboard (RUN only):
- busy[a] is cleared by a W0 or W1 write to a.
- busy[a] is set by bset with bwa==a.
- Set and clear on the same address in the same cycle: set wins, because the new producer is younger.
- busy[0] is constant 0; bset with bwa=0 is ignored.
- busy_rd[k] = busy[ra[k]], combinational, and does not reflect same-cycle set/clear.

Width rules:
- No arithmetic on data; data is stored and returned unmodified.
- cnt is AW bits wide; its wrap is never reached because the FSM leaves CLEAR first.

Optional Feature:
REGFILE_BYPASS_EN:
- Defined: write-through forwarding. In RUN, if ra[k]!=0 and matches an active write address this cycle, rd[k] returns that write's data (wd1 has priority over wd0). busy_rd[k] is forced to 0 when ra[k] matches an active write.
- Undefined: no forwarding; timing is exactly as stated under Reads.

Decomposition:
- Shared package regfile_pkg: FSM state encoding (ST_CLEAR, ST_RUN) and constant REG_ZERO = 0.
- DW, AW and NR remain module parameters.
- One sub-module, regfile_scoreboard: holds the busy bit vector and the set/clear priority logic, and drives busy_rd. It takes clk, rst, the write enables/addresses, bset/bwa and ra.
- The storage array and the clear FSM stay in regfile_mp.

Test Plan:
- Clear sweep: pulse rst 1 cycle with AW=5 -> ready=0 for exactly 32 cycles, then 1; all rd=0; a we0 issued during CLEAR leaves the register at 0.
- Basic write/read: we0 wa0=3 wd0=0xDEADBEEF, then ra[0]=3 next cycle -> rd[0]=0xDEADBEEF. A write to addr 0 followed by a read of addr 0 -> 0.
- Dual-write collision: we0 wa0=5 wd0=0x11 and we1 wa1=5 wd1=0x22 in the same cycle -> rd=0x22 next cycle. Different addresses 6 and 7 -> both stored.
- Scoreboard: bset bwa=8 -> busy_rd=1 next cycle. we1 wa1=8 -> busy_rd=0. Simultaneous bset bwa=8 and we0 wa0=8 -> busy stays 1.
- Reset mid-operation: rst asserted at cnt=10 during CLEAR, and again in RUN with busy[4]=1 -> sweep restarts with 32 more cycles; busy[4]=0; all registers read 0.
- Bypass (REGFILE_BYPASS_EN defined): we0 wa0=9 wd0=0x55 with ra[1]=9 in the same cycle -> rd[1]=0x55 in that cycle. With the macro undefined, the same stimulus -> rd[1] holds the old value and reads 0x55 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: the clear/run state encoding
// and the hard-wired zero register address.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection. A new producer (bset) takes priority
// over a retiring write to the same register. Forwarding mode: REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned NR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic             bset,
    input  logic [AW-1:0]    bwa,
    input  logic [NR*AW-1:0] ra,
    output logic [NR-1:0]    busy_rd
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Clears first, set last: the younger producer wins.
    always_comb begin
        busy_nxt = busy;
        if (we0) busy_nxt[wa0] = 1'b0;
        if (we1) busy_nxt[wa1] = 1'b0;
        if (bset) busy_nxt[bwa] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (run) begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        busy_rd = '0;
        for (int k = 0; k < NR; k++) begin
            busy_rd[k] = busy[ra[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (run && ra[k*AW +: AW] != AW'(REG_ZERO) &&
                ((we0 && wa0 == ra[k*AW +: AW]) || (we1 && wa1 == ra[k*AW +: AW]))) begin
                busy_rd[k] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write-port register file with combinational reads, a busy-bit scoreboard and a
// post-reset clear sweep. Optional write-through forwarding: REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned NR = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    busy_rd,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             bset,
    input  logic [AW-1:0]    bwa
);

    localparam int unsigned   DEPTH   = 2 ** AW;
    localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO_A  = AW'(REG_ZERO);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] rf [DEPTH];
    logic          run;
    logic          wr0;
    logic          wr1;

    assign run = (state == ST_RUN);
    assign wr0 = run && we0 && (wa0 != ZERO_A);
    assign wr1 = run && we1 && (wa1 != ZERO_A);

    // Clear sweep: one entry per cycle, then hand over to normal operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + AW'(1);
            if (cnt == CNT_MAX) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end
    end

    // Storage has no reset so it can map onto distributed RAM; W1 is written last and wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                rf[cnt] <= '0;
            end else begin
                if (wr0) rf[wa0] <= wd0;
                if (wr1) rf[wa1] <= wd1;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int k = 0; k < NR; k++) begin
            if (run && ra[k*AW +: AW] != ZERO_A) begin
                rd[k*DW +: DW] = rf[ra[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (wr0 && wa0 == ra[k*AW +: AW]) rd[k*DW +: DW] = wd0;
                if (wr1 && wa1 == ra[k*AW +: AW]) rd[k*DW +: DW] = wd1;
`endif
            end
        end
    end

    regfile_scoreboard #(
        .AW (AW),
        .NR (NR)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .we0     (we0),
        .wa0     (wa0),
        .we1     (we1),
        .wa1     (wa1),
        .bset    (bset),
        .bwa     (bwa),
        .ra      (ra),
        .busy_rd (busy_rd)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (DW=32, AW=5, NR=2): clear sweep, writes, collisions,
// scoreboard priority, resets in CLEAR and RUN, and same-cycle forwarding.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic             clk;
    logic             rst;
    logic             ready;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    busy_rd;
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [DW-1:0]    wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [DW-1:0]    wd1;
    logic             bset;
    logic [AW-1:0]    bwa;

    int checks;
    int failures;

    regfile_mp #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .ra      (ra),
        .rd      (rd),
        .busy_rd (busy_rd),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .bset    (bset),
        .bwa     (bwa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          bset;
        logic [AW-1:0] bwa;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] exp_rd0;
        logic [DW-1:0] exp_rd1;
        logic          exp_b0;
        logic          exp_b1;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        bset = 1'b0; bwa = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    // Counts cycles from reset release until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        idle();
        set_ra('0, '0);
        rst = 1'b1;
        tick();
        tick();
        chk("reset_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;

        // Initial sweep, with writes and bset attempted throughout CLEAR.
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hFFFF_FFFF;
        bset = 1'b1; bwa = 5'd2;
        set_ra(5'd2, 5'd2);
        n = 0;
        while (!ready && n < 100) begin
            #1;
            if (n == 5) begin
                chk("clear_rd0", rd[DW-1:0], 32'd0);
                chk("clear_busy", {30'b0, busy_rd}, 32'd0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        idle();
        chk("clear_cycles", 32'(n), 32'd32);
        #1;
        chk("post_clear_rd2", rd[DW-1:0], 32'd0);
        chk("post_clear_busy2", {30'b0, busy_rd}, 32'd0);

        tv[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[1]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tv[2]  = '{1'b1, 5'd5, 32'h11,       1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 5'd6, 32'hA6,       1'b1, 5'd7, 32'hB7, 1'b0, 5'd0, 5'd5, 5'd0, 32'h22,       32'h0,        1'b0, 1'b0};
        tv[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd8, 5'd6, 5'd7, 32'hA6,       32'hB7,       1'b0, 1'b0};
        tv[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd8, 5'd3, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 5'd3, 5'd5, 32'hDEADBEEF, 32'h22,       1'b0, 1'b0};
        tv[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd8, 5'd8, 32'h88,       32'h88,       1'b0, 1'b0};
        tv[8]  = '{1'b1, 5'd8, 32'h99,       1'b0, 5'd0, 32'h0,  1'b1, 5'd8, 5'd6, 5'd0, 32'hA6,       32'h0,        1'b0, 1'b0};
        tv[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd8, 5'd7, 32'h99,       32'hB7,       1'b1, 1'b0};
        tv[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd8, 32'h0,        32'h99,       1'b0, 1'b1};
        tv[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd0, 32'h0,        32'h0,        1'b1, 1'b0};

        for (int i = 0; i < 13; i++) begin
            we0 = tv[i].we0; wa0 = tv[i].wa0; wd0 = tv[i].wd0;
            we1 = tv[i].we1; wa1 = tv[i].wa1; wd1 = tv[i].wd1;
            bset = tv[i].bset; bwa = tv[i].bwa;
            set_ra(tv[i].ra0, tv[i].ra1);
            #1;
            chk($sformatf("vec%0d_rd0", i), rd[DW-1:0], tv[i].exp_rd0);
            chk($sformatf("vec%0d_rd1", i), rd[2*DW-1:DW], tv[i].exp_rd1);
            chk($sformatf("vec%0d_busy0", i), {31'b0, busy_rd[0]}, {31'b0, tv[i].exp_b0});
            chk($sformatf("vec%0d_busy1", i), {31'b0, busy_rd[1]}, {31'b0, tv[i].exp_b1});
            tick();
        end
        idle();

        // Reset while running with busy[4] set and data present.
        pulse_rst();
        chk("run_rst_ready", {31'b0, ready}, 32'd0);
        wait_ready(n);
        chk("run_rst_cycles", 32'(n), 32'd32);
        set_ra(5'd4, 5'd3);
        #1;
        chk("run_rst_busy4", {31'b0, busy_rd[0]}, 32'd0);
        chk("run_rst_rd3", rd[2*DW-1:DW], 32'd0);
        set_ra(5'd8, 5'd6);
        #1;
        chk("run_rst_rd8", rd[DW-1:0], 32'd0);
        chk("run_rst_rd6", rd[2*DW-1:DW], 32'd0);

        // Reset again part-way through the sweep (cnt = 10).
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFE_F00D;
        tick();
        idle();
        set_ra(5'd3, 5'd0);
        #1;
        chk("pre_mid_rd3", rd[DW-1:0], 32'hCAFE_F00D);
        pulse_rst();
        for (int i = 0; i < 10; i++) tick();
        chk("mid_clear_ready", {31'b0, ready}, 32'd0);
        pulse_rst();
        wait_ready(n);
        chk("mid_rst_cycles", 32'(n), 32'd32);
        #1;
        chk("mid_rst_rd3", rd[DW-1:0], 32'd0);

        // Same-cycle write and read of register 9.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55;
        set_ra(5'd0, 5'd9);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_rd1", rd[2*DW-1:DW], 32'h55);
`else
        chk("same_cycle_rd1", rd[2*DW-1:DW], 32'h0);
`endif
        tick();
        idle();
        #1;
        chk("next_cycle_rd1", rd[2*DW-1:DW], 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
